// File: rtl/instr_fetch_seq_pkg.sv
// Opcode map, sequencer state encoding and instruction-word layout shared by
// the fetch sequencer and the control unit.
package instr_fetch_seq_pkg;

  localparam logic [3:0] OP_ALU0  = 4'h0;
  localparam logic [3:0] OP_ALU1  = 4'h1;
  localparam logic [3:0] OP_ALU2  = 4'h2;
  localparam logic [3:0] OP_ALU3  = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  // ALU ops, LOAD and STORE occupy the contiguous range 0..5 and need the datapath.
  function automatic logic is_exec_op(input logic [3:0] op);
    return op <= OP_STORE;
  endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// Fetch/decode sequencer: fetches a 16-bit word at pc, decodes it and hands it
// to the datapath (EXEC) until exec_done; JUMP/NOP/HALT are resolved in DECODE.
module instr_fetch_seq
  import instr_fetch_seq_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [7:0]      mem_addr,
  output logic            instr_valid,
  input  logic            exec_done,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  fetch_state_t    state;
  instr_t          ir;
  logic [PC_W-1:0] jump_tgt;

  // Decoded fields come from the instruction register only, so they stay
  // stable through EXEC regardless of what the memory bus is doing.
  assign opcode    = ir.opcode;
  assign rd        = ir.rd;
  assign rs1       = ir.rs1;
  assign rs2       = ir.rs2;
  assign mem_addr  = {ir.rs1, ir.rs2};
  assign imem_addr = pc;
  assign jump_tgt  = PC_W'({ir.rs1, ir.rs2});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      imem_req    <= 1'b1;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            ir       <= imem_rdata;
            pc       <= pc + PC_W'(1);
            imem_req <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_exec_op(ir.opcode)) begin
            instr_valid <= 1'b1;
            state       <= ST_EXEC;
          end else if (ir.opcode == OP_JUMP) begin
            pc       <= jump_tgt;
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end else if (ir.opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            // Unassigned opcodes behave as NOP: straight back to fetch.
            imem_req <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= ST_FETCH;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          instr_valid <= 1'b0;
          halted      <= 1'b0;
          imem_req    <= 1'b1;
          state       <= ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: directed vector table, corner sequences and a
// randomized run against an instruction-level reference model.
module tb_instr_fetch_seq;
  import instr_fetch_seq_pkg::*;

  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_rdata;
  logic            imem_ack;
  logic [3:0]      opcode, rd, rs1, rs2;
  logic [7:0]      mem_addr;
  logic            instr_valid;
  logic            exec_done;
  logic [PC_W-1:0] pc;
  logic            halted;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_seq #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .opcode(opcode), .rd(rd),
    .rs1(rs1), .rs2(rs2), .mem_addr(mem_addr), .instr_valid(instr_valid),
    .exec_done(exec_done), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_fields(input string name, input logic [15:0] w);
    chk({name, "_opcode"}, opcode, w[15:12]);
    chk({name, "_rd"}, rd, w[11:8]);
    chk({name, "_rs1"}, rs1, w[7:4]);
    chk({name, "_rs2"}, rs2, w[3:0]);
    chk({name, "_mem_addr"}, mem_addr, w[7:0]);
  endtask

  // Leaves the bench at a falling edge with rst just released: the next
  // rising edge is the first post-reset FETCH cycle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; imem_rdata = '0;
    @(negedge clk);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_opcode", opcode, 4'h0);
    rst = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic        exp_valid;
    logic        exp_req;
    logic        exp_halt;
    logic [7:0]  exp_pc;
  } vec_t;

  typedef enum {M_WAIT, M_DEC, M_EXEC, M_HALT} mmode_t;

  vec_t        tbl[9];
  logic [15:0] mem[256];
  logic [3:0]  op;
  int          r;

  initial begin
    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; imem_rdata = '0;

    tbl[0] = '{"alu0",  16'h0123, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[1] = '{"alu3",  16'h3ABC, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[2] = '{"load",  16'h4F12, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[3] = '{"store", 16'h5E77, 1'b1, 1'b0, 1'b0, 8'h01};
    tbl[4] = '{"jump",  16'h60A5, 1'b0, 1'b1, 1'b0, 8'hA5};
    tbl[5] = '{"nop7",  16'h7123, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[6] = '{"nopE",  16'hE456, 1'b0, 1'b1, 1'b0, 8'h01};
    tbl[7] = '{"halt",  16'hF000, 1'b0, 1'b0, 1'b1, 8'h01};
    tbl[8] = '{"alu1",  16'h1FED, 1'b1, 1'b0, 1'b0, 8'h01};

    // Table: one instruction fetched straight out of reset.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      imem_ack = 1'b1; imem_rdata = tbl[i].rdata;
      @(negedge clk);
      imem_ack = 1'b0;
      chk({tbl[i].name, "_dec_valid"}, instr_valid, 1'b0);
      chk({tbl[i].name, "_dec_req"}, imem_req, 1'b0);
      @(negedge clk);
      chk({tbl[i].name, "_valid"}, instr_valid, tbl[i].exp_valid);
      chk({tbl[i].name, "_req"}, imem_req, tbl[i].exp_req);
      chk({tbl[i].name, "_halted"}, halted, tbl[i].exp_halt);
      chk({tbl[i].name, "_pc"}, pc, tbl[i].exp_pc);
      chk({tbl[i].name, "_addr"}, imem_addr, tbl[i].exp_pc);
      if (tbl[i].exp_valid) begin
        chk_fields(tbl[i].name, tbl[i].rdata);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk({tbl[i].name, "_post_req"}, imem_req, 1'b1);
        chk({tbl[i].name, "_post_valid"}, instr_valid, 1'b0);
      end
    end

    // Ack withheld: request held, address and pc frozen.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, 8'h00);
      chk("stall_valid", instr_valid, 1'b0);
      chk("stall_pc", pc, 8'h00);
    end

    // HALT is sticky against ack/exec_done; reset clears it.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 16'hF000;
    @(negedge clk);
    imem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_halted", halted, 1'b1);
      chk("halt_req", imem_req, 1'b0);
      chk("halt_valid", instr_valid, 1'b0);
      chk("halt_pc", pc, 8'h01);
      imem_ack = 1'b1; exec_done = i[0]; imem_rdata = 16'h0123;
    end
    imem_ack = 1'b0; exec_done = 1'b0;
    do_reset();

    // PC wrap: jump to FF, fetch there, pc returns to 00.
    imem_ack = 1'b1; imem_rdata = 16'h60FF;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("wrap_addr", imem_addr, 8'hFF);
    imem_ack = 1'b1; imem_rdata = 16'h7000;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("wrap_pc", pc, 8'h00);

    // Ack during DECODE is ignored; reset in EXEC with exec_done high.
    do_reset();
    imem_ack = 1'b1; imem_rdata = 16'h0123;
    @(negedge clk);
    imem_rdata = 16'hF0F0;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("decack_valid", instr_valid, 1'b1);
    chk("decack_opcode", opcode, 4'h0);
    chk("decack_rd", rd, 4'h1);
    chk("decack_pc", pc, 8'h01);
    exec_done = 1'b1; rst = 1'b1;
    #1;
    chk("exrst_valid", instr_valid, 1'b0);
    chk("exrst_pc", pc, 8'h00);
    chk("exrst_req", imem_req, 1'b1);
    @(negedge clk);
    rst = 1'b0; exec_done = 1'b0;
    @(negedge clk);
    chk("exrst_pc_hold", pc, 8'h00);
    chk("exrst_req_hold", imem_req, 1'b1);
    chk("exrst_valid_hold", instr_valid, 1'b0);

    // Randomized program run against an instruction-level model.
    for (int i = 0; i < 256; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      op = 4'($urandom_range(0, 5));
      else if (r < 70) op = OP_JUMP;
      else if (r < 96) op = 4'($urandom_range(7, 14));
      else             op = OP_HALT;
      mem[i] = {op, 12'($urandom)};
    end
    begin
      mmode_t     mode;
      logic [7:0] m_pc;
      logic [15:0] cur;
      int         halt_cnt;
      do_reset();
      mode = M_WAIT; m_pc = 8'h00; cur = 16'h0000; halt_cnt = 0;
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
        chk("rnd_req", imem_req, mode == M_WAIT);
        chk("rnd_valid", instr_valid, mode == M_EXEC);
        chk("rnd_halted", halted, mode == M_HALT);
        chk("rnd_pc", pc, m_pc);
        chk("rnd_addr", imem_addr, m_pc);
        if (mode == M_EXEC) chk_fields("rnd", cur);

        if ((mode == M_HALT && halt_cnt >= 6) || $urandom_range(0, 299) == 0) begin
          rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0;
          mode = M_WAIT; m_pc = 8'h00; halt_cnt = 0;
          @(negedge clk);
          rst = 1'b0;
          continue;
        end

        imem_ack   = ($urandom_range(0, 9) < 6);
        exec_done  = ($urandom_range(0, 9) < 4);
        imem_rdata = imem_ack ? mem[m_pc] : 16'($urandom);

        case (mode)
          M_WAIT: if (imem_ack) begin
            cur  = mem[m_pc];
            m_pc = m_pc + 8'd1;
            mode = M_DEC;
          end
          M_DEC: begin
            if (cur[15:12] <= 4'd5)        mode = M_EXEC;
            else if (cur[15:12] == 4'd6) begin
              m_pc = cur[7:0];
              mode = M_WAIT;
            end
            else if (cur[15:12] == 4'hF)   mode = M_HALT;
            else                           mode = M_WAIT;
          end
          M_EXEC: if (exec_done) mode = M_WAIT;
          M_HALT: halt_cnt++;
          default: mode = M_WAIT;
        endcase
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
